// File: rtl/gpio_input_conditioner.sv
// Input conditioner for the GPIO read bus: 2-FF synchroniser, counter debounce, sticky edge flags.
// Optional macro GPIO_IN_IRQ_EN adds a registered io_irq (OR of all rise/fall flags).
module gpio_input_conditioner #(
    parameter int unsigned           WIDTH           = 2,
    parameter int unsigned           DEBOUNCE_CYCLES = 240000,
    parameter logic [WIDTH-1:0]      INIT_LEVEL      = '0
) (
    input  logic             io_mainClk,
    input  logic             io_asyncReset_n,
    input  logic [WIDTH-1:0] io_pinsRaw,
    input  logic             io_clearStrobe,
    input  logic [WIDTH-1:0] io_clearMask,
    output logic [WIDTH-1:0] io_level,
    output logic [WIDTH-1:0] io_rise,
    output logic [WIDTH-1:0] io_fall,
`ifdef GPIO_IN_IRQ_EN
    output logic             io_irq,
`endif
    output logic [31:0]      io_gpioRead
);

    localparam int unsigned   CntW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [CntW-1:0]  cnt_q [WIDTH];
    logic [CntW-1:0]  cnt_d [WIDTH];

    // Clear is applied first so a same-edge event set overrides it.
    always_comb begin
        level_d = level_q;
        rise_d  = rise_q;
        fall_d  = fall_q;
        cnt_d   = cnt_q;
        if (io_clearStrobe) begin
            rise_d = rise_q & ~io_clearMask;
            fall_d = fall_q & ~io_clearMask;
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                level_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
                if (sync2_q[i]) begin
                    rise_d[i] = 1'b1;
                end else begin
                    fall_d[i] = 1'b1;
                end
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
        if (!io_asyncReset_n) begin
            sync1_q <= INIT_LEVEL;
            sync2_q <= INIT_LEVEL;
            level_q <= INIT_LEVEL;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= io_pinsRaw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef GPIO_IN_IRQ_EN
    logic irq_q;

    // Loaded from next-state flags so the irq tracks the flags on the same edge.
    always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
        if (!io_asyncReset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |{rise_d, fall_d};
        end
    end

    assign io_irq = irq_q;
`endif

    assign io_level    = level_q;
    assign io_rise     = rise_q;
    assign io_fall     = fall_q;
    assign io_gpioRead = {8'h00, 8'(fall_q), 8'(rise_q), 8'(level_q)};

endmodule
